// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - round-robin arbiter sharing one memory line port between I-cache and D-cache
//
// Purpose: accepts whole-line requests from the I-cache (read only) and the
// D-cache (read or writeback), serialises them one at a time onto the memory
// line port, and returns the completion (and read line) to the granted cache.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   i_pmem_*          I-cache side: read request/address in, rdata/resp out
//   d_pmem_*          D-cache side: read/write request, address, wdata in,
//                     rdata/resp out
//   pmem_*            memory side: read/write/address/wdata out (registered),
//                     rdata/resp in
//   i_grant_count     wrapping count of grants given to the I-cache
//   d_grant_count     wrapping count of grants given to the D-cache

module cache_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,

  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,

  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,

  output logic [CNT_WIDTH-1:0]  i_grant_count,
  output logic [CNT_WIDTH-1:0]  d_grant_count
);

  // Byte-offset bits inside one line; these are cleared on the memory address.
  localparam int OFFS_BITS = $clog2(LINE_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    {{(ADDR_WIDTH - OFFS_BITS){1'b1}}, {OFFS_BITS{1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                state;
  logic                  last_grant_d;  // 1: D-cache was served last, 0: I-cache
  logic                  served_d;      // client owning the current transaction
  logic [LINE_WIDTH-1:0] line_buf;

  logic i_req;
  logic d_req;
  logic pick_i;
  logic pick_d;

  // Grant decision, only acted on in IDLE. On a tie the client that was not
  // served last wins; after reset last_grant_d=0 so the first tie goes to D.
  always_comb begin
    i_req  = i_pmem_read;
    d_req  = d_pmem_read | d_pmem_write;
    pick_d = d_req && (!i_req || !last_grant_d);
    pick_i = i_req && !pick_d;
  end

  // Both caches see the shared line buffer; each only looks at it during its
  // own resp pulse.
  assign i_pmem_rdata = line_buf;
  assign d_pmem_rdata = line_buf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      last_grant_d  <= 1'b0;
      served_d      <= 1'b0;
      line_buf      <= '0;
      pmem_read     <= 1'b0;
      pmem_write    <= 1'b0;
      pmem_address  <= '0;
      pmem_wdata    <= '0;
      i_pmem_resp   <= 1'b0;
      d_pmem_resp   <= 1'b0;
      i_grant_count <= '0;
      d_grant_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            // A simultaneous read+write from the D-cache is served as a write.
            state         <= SERVE_D;
            served_d      <= 1'b1;
            pmem_address  <= d_pmem_address & LINE_MASK;
            pmem_wdata    <= d_pmem_wdata;
            pmem_write    <= d_pmem_write;
            pmem_read     <= !d_pmem_write;
            d_grant_count <= d_grant_count + 1'b1;
          end else if (pick_i) begin
            state         <= SERVE_I;
            served_d      <= 1'b0;
            pmem_address  <= i_pmem_address & LINE_MASK;
            pmem_write    <= 1'b0;
            pmem_read     <= 1'b1;
            i_grant_count <= i_grant_count + 1'b1;
          end
        end

        // Requests are not looked at here: the transaction runs to completion
        // even if the client withdraws its request.
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            if (pmem_read) begin
              line_buf <= pmem_rdata;
            end
            pmem_read   <= 1'b0;
            pmem_write  <= 1'b0;
            i_pmem_resp <= !served_d;
            d_pmem_resp <= served_d;
            state       <= DONE;
          end
        end

        DONE: begin
          i_pmem_resp  <= 1'b0;
          d_pmem_resp  <= 1'b0;
          last_grant_d <= served_d;
          state        <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // Read and write together from the D-cache is a client bug; the write wins.
  a_d_rw_exclusive: assert property (
    @(posedge clk) disable iff (!rst) !(d_pmem_read && d_pmem_write)
  );
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - self-checking bench for cache_arbiter

module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;
  localparam int CW = 2;

  typedef logic [LW-1:0] line_t;
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    line_t       wdata;
  } txn_t;

  localparam logic [31:0] MASK = 32'hFFFF_FFE0;

  logic          clk;
  logic          rst;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  line_t         i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  line_t         d_pmem_wdata;
  line_t         d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  line_t         pmem_wdata;
  line_t         pmem_rdata;
  logic          pmem_resp;
  logic [CW-1:0] i_grant_count;
  logic [CW-1:0] d_grant_count;

  cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp),
    .i_grant_count  (i_grant_count),
    .d_grant_count  (d_grant_count)
  );

  int    n_cmp  = 0;
  int    n_fail = 0;
  int    mem_lat = 2;
  line_t mem [logic [31:0]];
  txn_t  mem_log [$];

  // Reference state: who was served last and how many grants each client got.
  bit last_d = 0;
  int mi = 0;
  int md = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic line_t mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  // Memory model: one transaction at a time, resp after mem_lat cycles,
  // command must be held stable meanwhile and dropped after resp.
  initial begin : responder
    txn_t t;
    bit   aborted;
    pmem_resp  = 0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst && (pmem_read || pmem_write)) begin
        t.wr    = pmem_write;
        t.addr  = pmem_address;
        t.wdata = pmem_wdata;
        aborted = 0;
        for (int c = 1; c < mem_lat; c++) begin
          @(negedge clk);
          if (!rst) begin
            aborted = 1;
            break;
          end
          n_cmp++;
          if (pmem_read !== !t.wr || pmem_write !== t.wr ||
              pmem_address !== t.addr || pmem_wdata !== t.wdata) begin
            n_fail++;
            $display("FAIL hold: rd=%b wr=%b addr=%h required rd=%b wr=%b addr=%h",
                     pmem_read, pmem_write, pmem_address, !t.wr, t.wr, t.addr);
          end
        end
        if (!aborted) begin
          if (t.wr) mem[t.addr] = t.wdata;
          else pmem_rdata = mem_rd(t.addr);
          pmem_resp = 1;
          mem_log.push_back(t);
          @(negedge clk);
          pmem_resp = 0;
          for (int w = 0; w < 8; w++) pmem_rdata[w*32 +: 32] = $urandom();
          n_cmp++;
          if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL op_drop: rd=%b wr=%b required 0 0", pmem_read, pmem_write);
          end
        end
      end
    end
  end

  // Issue one round of requests (I, D or both raised in the same cycle) and
  // check service order, memory commands, read data and counters.
  task automatic issue(input bit do_i, input bit do_d, input bit d_wr,
                       input logic [31:0] ai, input logic [31:0] ad, input line_t wd);
    bit exp_cl[$];
    bit got_cl[$];
    bit pend_i = do_i;
    bit pend_d = do_d;
    int cyc = 0;
    if (do_i && do_d) begin
      if (last_d) begin exp_cl.push_back(0); exp_cl.push_back(1); end
      else begin exp_cl.push_back(1); exp_cl.push_back(0); end
    end else if (do_i) exp_cl.push_back(0);
    else if (do_d) exp_cl.push_back(1);
    mem_log.delete();
    @(negedge clk);
    i_pmem_read    = do_i;
    i_pmem_address = ai;
    d_pmem_read    = do_d && !d_wr;
    d_pmem_write   = do_d && d_wr;
    d_pmem_address = ad;
    d_pmem_wdata   = wd;
    while ((pend_i || pend_d) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (i_pmem_resp) begin
        got_cl.push_back(0);
        if (do_i) begin
          n_cmp++;
          if (i_pmem_rdata !== mem_rd(ai & MASK)) begin
            n_fail++;
            $display("FAIL i_rdata: got=%h required=%h", i_pmem_rdata, mem_rd(ai & MASK));
          end
        end
        i_pmem_read = 0;
        pend_i = 0;
      end
      if (d_pmem_resp) begin
        got_cl.push_back(1);
        if (do_d && !d_wr) begin
          n_cmp++;
          if (d_pmem_rdata !== mem_rd(ad & MASK)) begin
            n_fail++;
            $display("FAIL d_rdata: got=%h required=%h", d_pmem_rdata, mem_rd(ad & MASK));
          end
        end
        d_pmem_read  = 0;
        d_pmem_write = 0;
        pend_d = 0;
      end
    end
    n_cmp++;
    if (pend_i || pend_d) begin
      n_fail++;
      $display("FAIL timeout: pending i=%b d=%b required 0 0", pend_i, pend_d);
    end
    @(negedge clk);
    n_cmp++;
    if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin
      n_fail++;
      $display("FAIL resp_width: i=%b d=%b required 0 0", i_pmem_resp, d_pmem_resp);
    end
    n_cmp++;
    if (got_cl.size() != exp_cl.size()) begin
      n_fail++;
      $display("FAIL order_len: got=%0d required=%0d", got_cl.size(), exp_cl.size());
    end else begin
      foreach (exp_cl[k]) begin
        if (got_cl[k] != exp_cl[k]) begin
          n_fail++;
          $display("FAIL order[%0d]: got=%0d required=%0d (0=I 1=D)", k, got_cl[k], exp_cl[k]);
        end
      end
    end
    n_cmp++;
    if (mem_log.size() != exp_cl.size()) begin
      n_fail++;
      $display("FAIL txn_count: got=%0d required=%0d", mem_log.size(), exp_cl.size());
    end else begin
      foreach (exp_cl[k]) begin
        logic [31:0] ea;
        bit          ew;
        ea = (exp_cl[k] ? ad : ai) & MASK;
        ew = exp_cl[k] ? d_wr : 1'b0;
        if (mem_log[k].addr !== ea || mem_log[k].wr != ew ||
            (ew && mem_log[k].wdata !== wd)) begin
          n_fail++;
          $display("FAIL txn[%0d]: addr=%h wr=%0d required addr=%h wr=%0d",
                   k, mem_log[k].addr, mem_log[k].wr, ea, ew);
        end
      end
    end
    foreach (exp_cl[k]) begin
      if (exp_cl[k]) md = (md + 1) % (1 << CW);
      else mi = (mi + 1) % (1 << CW);
    end
    if (exp_cl.size() > 0) last_d = exp_cl[exp_cl.size()-1];
    n_cmp++;
    if (i_grant_count !== CW'(mi) || d_grant_count !== CW'(md)) begin
      n_fail++;
      $display("FAIL counts: i=%0d d=%0d required i=%0d d=%0d",
               i_grant_count, d_grant_count, mi, md);
    end
  endtask

  task automatic test_reset;
    i_pmem_read = 0; i_pmem_address = '0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
    rst = 1;
    #1 rst = 0;
    @(negedge clk);
    n_cmp++;
    if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0 ||
        pmem_address !== '0 || pmem_wdata !== '0 || i_pmem_rdata !== '0 ||
        d_pmem_rdata !== '0 || i_grant_count !== '0 || d_grant_count !== '0) begin
      n_fail++;
      $display("FAIL reset_state: rd=%b wr=%b addr=%h cnt=%0d/%0d required all 0",
               pmem_read, pmem_write, pmem_address, i_grant_count, d_grant_count);
    end
    @(negedge clk);
    rst = 1;
    // Reset asserted in the middle of a D writeback.
    mem_lat = 50;
    d_pmem_write = 1; d_pmem_address = 32'h0000_0440; d_pmem_wdata = {8{32'hDEAD_BEEF}};
    for (int c = 0; c < 20 && !pmem_write; c++) @(negedge clk);
    n_cmp++;
    if (pmem_write !== 1'b1 || d_grant_count !== 2'd1) begin
      n_fail++;
      $display("FAIL mid_write_setup: wr=%b dcnt=%0d required 1 1", pmem_write, d_grant_count);
    end
    @(negedge clk);
    #2 rst = 0;
    #1;
    n_cmp++;
    if (pmem_write !== 1'b0 || d_pmem_resp !== 1'b0 ||
        i_grant_count !== '0 || d_grant_count !== '0) begin
      n_fail++;
      $display("FAIL reset_abort: wr=%b dresp=%b cnt=%0d/%0d required 0 0 0/0",
               pmem_write, d_pmem_resp, i_grant_count, d_grant_count);
    end
    @(negedge clk);
    d_pmem_write = 0;
    @(negedge clk);
    rst = 1;
    mem_lat = 2;
    mi = 0; md = 0; last_d = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0 ||
          i_grant_count !== '0 || d_grant_count !== '0) begin
        n_fail++;
        $display("FAIL idle_after_reset: rd=%b wr=%b iresp=%b dresp=%b required 0",
                 pmem_read, pmem_write, i_pmem_resp, d_pmem_resp);
      end
    end
  endtask

  task automatic test_single_i_read;
    mem[32'h0000_1220] = {32{8'hA5}};
    mem_lat = 3;
    mem_log.delete();
    @(negedge clk);
    i_pmem_read = 1; i_pmem_address = 32'h0000_1234;
    @(negedge clk);
    n_cmp++;
    if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 32'h0000_1220) begin
      n_fail++;
      $display("FAIL grant_latency: rd=%b wr=%b addr=%h required 1 0 00001220",
               pmem_read, pmem_write, pmem_address);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (i_pmem_resp !== 1'b0) begin
        n_fail++;
        $display("FAIL early_resp: got=%b required 0", i_pmem_resp);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (i_pmem_resp !== 1'b1 || i_pmem_rdata !== {32{8'hA5}}) begin
      n_fail++;
      $display("FAIL resp_latency: resp=%b rdata=%h required 1 a5..a5", i_pmem_resp, i_pmem_rdata);
    end
    i_pmem_read = 0;
    @(negedge clk);
    n_cmp++;
    if (i_pmem_resp !== 1'b0 || i_grant_count !== 2'd1 || d_grant_count !== 2'd0) begin
      n_fail++;
      $display("FAIL single_i_end: resp=%b icnt=%0d dcnt=%0d required 0 1 0",
               i_pmem_resp, i_grant_count, d_grant_count);
    end
    mi = 1; last_d = 0;
    mem_lat = 2;
  endtask

  task automatic test_tie;
    line_t z = '0;
    issue(1, 1, 0, 32'h0000_2000, 32'h0000_3000, z);
    issue(1, 1, 0, 32'h0000_2040, 32'h0000_3040, z);
  endtask

  task automatic test_d_writeback;
    line_t p;
    for (int w = 0; w < 8; w++) p[w*32 +: 32] = $urandom();
    mem_lat = 4;
    issue(0, 1, 1, 32'h0, 32'h8000_0040, p);
    issue(0, 1, 0, 32'h0, 32'h8000_0047, p);
    mem_lat = 2;
  endtask

  task automatic test_dropped;
    int pulses = 0;
    mem_lat = 5;
    mem_log.delete();
    @(negedge clk);
    i_pmem_read = 1; i_pmem_address = 32'h0000_5000;
    @(negedge clk);
    @(negedge clk);
    i_pmem_read = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (i_pmem_resp) pulses++;
    end
    n_cmp++;
    if (pulses != 1 || mem_log.size() != 1 || pmem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL dropped: pulses=%0d txns=%0d rd=%b required 1 1 0",
               pulses, mem_log.size(), pmem_read);
    end
    mi = (mi + 1) % (1 << CW); last_d = 0;
    mem_lat = 2;
    issue(0, 1, 0, 32'h0, 32'h0000_5000, '0);
  endtask

  task automatic test_random;
    for (int r = 0; r < 24; r++) begin
      int    sel;
      line_t wd;
      logic [31:0] ai;
      logic [31:0] ad;
      sel = $urandom_range(1, 3);
      ai  = 32'h0001_0000 + $urandom_range(0, 255);
      ad  = 32'h0001_0000 + $urandom_range(0, 255);
      for (int w = 0; w < 8; w++) wd[w*32 +: 32] = $urandom();
      mem_lat = $urandom_range(1, 4);
      issue(sel[0], sel[1], 1'($urandom_range(0, 1)), ai, ad, wd);
    end
    mem_lat = 2;
  endtask

  task automatic test_wrap;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    rst = 1;
    mi = 0; md = 0; last_d = 0;
    for (int k = 0; k < 5; k++) issue(1, 0, 0, 32'h0000_7000 + 32'(k * 32), 32'h0, '0);
    n_cmp++;
    if (i_grant_count !== 2'd1 || d_grant_count !== 2'd0) begin
      n_fail++;
      $display("FAIL wrap: icnt=%0d dcnt=%0d required 1 0", i_grant_count, d_grant_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_i_read();
    test_tie();
    test_d_writeback();
    test_dropped();
    test_random();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
